nmos_pmos: RTL and testbench
============================

# nmos_pmos

Clocked, four-state behavioural model of a bank of MOS pass switches with Verilog `nmos`/`pmos` semantics. Each lane is an nmos or a pmos switch. Each lane's output is registered, and all lane outputs are also resolved onto one shared tri-state net. It sits in the switch-level verification library, so gate-level cells such as pull-up/pull-down AND/NOR stacks can be checked against a synchronous, synthesizable reference.

## Interface
Parameters:
- LANES, default 4: number of switch lanes. Legal range is 1..16.

Ports:
- clk, input, 1: single clock. Everything samples on the rising edge.
- rst, input, 1: synchronous reset, active-high.
- in_valid, input, 1: qualifies data, gate and is_pmos for this cycle.
- data, input, 2*LANES: four-state source value per lane. Lane i uses bits [2i+1:2i].
- gate, input, 2*LANES: four-state gate value per lane.
- is_pmos, input, LANES: 1 makes the lane a pmos switch; 0 makes it an nmos switch.
- out_valid, output, 1: registered copy of in_valid.
- lane_out, output, 2*LANES: registered four-state drain value per lane.
- net_out, output, 2: registered resolution of all lanes onto one shared net.
- contention, output, 1: registered flag. High when two or more lanes drive the shared net to conflicting values.

## Operation
- Four-state encoding on every 2-bit field: 00 = 0, 01 = 1, 10 = Z, 11 = X.
- Effective gate: nmos lanes use gate as-is. pmos lanes use the gate inverted: 0↔1, while Z and X both map to X.
- Per-lane switch function, from effective gate g and data d:
  - g = 1: the output equals d, including Z and X.
  - g = 0: the output is Z.
  - g = X or Z: d = Z gives Z; d = 0, 1 or X gives X. Weak L/H levels are not modelled and collapse to X.
- Shared-net resolution over all lane outputs:
  - All lanes Z: the net is Z.
  - Every non-Z lane carries the same value v (0 or 1) and no lane is X: the net is v.
  - Any lane is X: the net is X and contention = 0.
  - Both a 0 and a 1 are present: the net is X and contention = 1.
- A lane with effective gate X/Z and data 0/1 contributes X; this does not set contention.
- Purely combinational evaluation feeds one register stage. There is no internal state beyond the output registers.

## Timing
- Latency is exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- in_valid = 1 at edge N: lane_out, net_out and contention update, and out_valid = 1.
- in_valid = 0 at edge N: lane_out, net_out and contention hold their previous values, and out_valid = 0.
- rst = 1 at an edge overrides in_valid. The required reset values are:
  - lane_out: all lanes Z (10).
  - net_out: Z (10).
  - contention: 0.
  - out_valid: 0.
- Reset asserted mid-stream discards the sample presented in that same cycle.
- Back-to-back valid cycles are accepted every cycle; there is no backpressure.
- Outputs are undefined before the first reset edge. The bench must reset first.

## Test plan
- Reset: hold rst = 1 for 2 cycles with arbitrary inputs -> lane_out = all 10, net_out = 10, contention = 0, out_valid = 0.
- nmos pass/block, LANES = 4, all is_pmos = 0, data = 01 on every lane:
  - gate = 01 on lane 0 and 00 elsewhere -> lane_out[1:0] = 01, other lanes 10, net_out = 01, contention = 0, one cycle after in_valid.
- pmos inversion: lane 0 is pmos with data = 00 and gate = 00 -> lane_out[1:0] = 00; with gate = 01 -> 10; with gate = 10 -> 11.
- Contention: lane 0 is nmos, gate 01, data 00; lane 1 is pmos, gate 00, data 01 -> net_out = 11, contention = 1.
- X propagation: one lane has gate 11 and data 01, all other lanes output Z -> net_out = 11, contention = 0.
- Hold and mid-stream reset:
  - Valid sample, then in_valid = 0 for 3 cycles -> outputs hold and out_valid = 0.
  - Then assert rst together with in_valid = 1 -> reset values; the sample is dropped.

Source files
------------

// File: rtl/nmos_pmos.sv
// Clocked four-state model of a bank of nmos/pmos pass switches.
// Every lane is also resolved onto one shared net. One register stage follows the combinational evaluation.
module nmos_pmos #(
    parameter int unsigned LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [2*LANES-1:0]   data,
    input  logic [2*LANES-1:0]   gate,
    input  logic [LANES-1:0]     is_pmos,
    output logic                 out_valid,
    output logic [2*LANES-1:0]   lane_out,
    output logic [1:0]           net_out,
    output logic                 contention
);

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        SZ = 2'b10,
        SX = 2'b11
    } fs_t;

    logic [2*LANES-1:0] lane_nxt;
    logic [1:0]         net_nxt;
    logic               cont_nxt;

    always_comb begin
        fs_t  d;
        fs_t  g;
        fs_t  o;
        logic has0;
        logic has1;
        logic hasx;
        lane_nxt = '0;
        net_nxt  = SZ;
        cont_nxt = 1'b0;
        d        = SZ;
        g        = SZ;
        o        = SZ;
        has0     = 1'b0;
        has1     = 1'b0;
        hasx     = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            d = fs_t'(data[2*i +: 2]);
            g = fs_t'(gate[2*i +: 2]);
            // A pmos gate inverts 0/1; Z and X on its gate both become X.
            if (is_pmos[i]) begin
                case (g)
                    S0:      g = S1;
                    S1:      g = S0;
                    default: g = SX;
                endcase
            end
            case (g)
                S1:      o = d;
                S0:      o = SZ;
                default: o = (d == SZ) ? SZ : SX;
            endcase
            lane_nxt[2*i +: 2] = o;
            has0 = has0 | (o == S0);
            has1 = has1 | (o == S1);
            hasx = hasx | (o == SX);
        end
        // An X on the net masks contention; only a clean 0-vs-1 fight flags it.
        if (hasx) begin
            net_nxt = SX;
        end else if (has0 && has1) begin
            net_nxt  = SX;
            cont_nxt = 1'b1;
        end else if (has0) begin
            net_nxt = S0;
        end else if (has1) begin
            net_nxt = S1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            lane_out   <= {LANES{SZ}};
            net_out    <= SZ;
            contention <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                lane_out   <= lane_nxt;
                net_out    <= net_nxt;
                contention <= cont_nxt;
            end
        end
    end

endmodule

// File: tb/tb_nmos_pmos.sv
// Self-checking bench for nmos_pmos: directed cases plus randomized traffic.
// The traffic is checked against a table-driven reference model.
module tb_nmos_pmos;

    localparam int LANES = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic [2*LANES-1:0]   data;
    logic [2*LANES-1:0]   gate;
    logic [LANES-1:0]     is_pmos;
    logic                 out_valid;
    logic [2*LANES-1:0]   lane_out;
    logic [1:0]           net_out;
    logic                 contention;

    always #5 clk = ~clk;

    nmos_pmos #(.LANES(LANES)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .data       (data),
        .gate       (gate),
        .is_pmos    (is_pmos),
        .out_valid  (out_valid),
        .lane_out   (lane_out),
        .net_out    (net_out),
        .contention (contention)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference register image
    logic [2*LANES-1:0] m_lane;
    logic [1:0]         m_net;
    logic               m_cont;
    logic               m_valid;

    // Switch truth table indexed [effective gate][data]; gate codes 0,1,Z,X
    logic [1:0] sw_tbl [4][4];
    // pmos gate mapping: 0->1, 1->0, Z->X, X->X
    logic [1:0] pgate  [4];

    initial begin
        for (int d = 0; d < 4; d++) begin
            sw_tbl[0][d] = 2'b10;
            sw_tbl[1][d] = 2'(d);
            sw_tbl[2][d] = (d == 2) ? 2'b10 : 2'b11;
            sw_tbl[3][d] = (d == 2) ? 2'b10 : 2'b11;
        end
        pgate[0] = 2'b01;
        pgate[1] = 2'b00;
        pgate[2] = 2'b11;
        pgate[3] = 2'b11;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [2*LANES-1:0] d, input logic [2*LANES-1:0] g,
                         input logic [LANES-1:0] p);
        int n0 = 0;
        int n1 = 0;
        int nx = 0;
        logic [1:0] ge;
        logic [1:0] o;
        for (int i = 0; i < LANES; i++) begin
            ge = p[i] ? pgate[g[2*i +: 2]] : g[2*i +: 2];
            o  = sw_tbl[ge][d[2*i +: 2]];
            m_lane[2*i +: 2] = o;
            if (o == 2'b00) n0++;
            if (o == 2'b01) n1++;
            if (o == 2'b11) nx++;
        end
        m_cont = 1'b0;
        if (nx > 0)                 m_net = 2'b11;
        else if (n0 > 0 && n1 > 0) begin m_net = 2'b11; m_cont = 1'b1; end
        else if (n0 > 0)            m_net = 2'b00;
        else if (n1 > 0)            m_net = 2'b01;
        else                        m_net = 2'b10;
    endtask

    task automatic drive(input logic r, input logic v, input logic [2*LANES-1:0] d,
                         input logic [2*LANES-1:0] g, input logic [LANES-1:0] p);
        rst      = r;
        in_valid = v;
        data     = d;
        gate     = g;
        is_pmos  = p;
        if (r) begin
            m_lane  = {LANES{2'b10}};
            m_net   = 2'b10;
            m_cont  = 1'b0;
            m_valid = 1'b0;
        end else begin
            m_valid = v;
            if (v) model(d, g, p);
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("lane_out", 32'(lane_out), 32'(m_lane));
        chk("net_out", 32'(net_out), 32'(m_net));
        chk("contention", 32'(contention), 32'(m_cont));
    endtask

    initial begin
        // Reset with arbitrary inputs
        drive(1'b1, 1'b1, 8'($urandom), 8'($urandom), 4'($urandom));
        drive(1'b1, 1'b0, 8'($urandom), 8'($urandom), 4'($urandom));
        chk("rst_lane_abs", 32'(lane_out), 32'h0000_00AA);
        chk("rst_net_abs", 32'(net_out), 32'h2);

        // nmos pass on lane 0, blocked elsewhere
        drive(1'b0, 1'b1, 8'b01_01_01_01, 8'b00_00_00_01, 4'b0000);
        chk("nmos_lane_abs", 32'(lane_out), 32'h0000_00A9);
        chk("nmos_net_abs", 32'(net_out), 32'h1);

        // pmos inversion on lane 0
        drive(1'b0, 1'b1, 8'b00_00_00_00, 8'b00_00_00_00, 4'b0001);
        chk("pmos_g0_abs", 32'(lane_out[1:0]), 32'h0);
        drive(1'b0, 1'b1, 8'b00_00_00_00, 8'b00_00_00_01, 4'b0001);
        chk("pmos_g1_abs", 32'(lane_out[1:0]), 32'h2);
        drive(1'b0, 1'b1, 8'b00_00_00_00, 8'b00_00_00_10, 4'b0001);
        chk("pmos_gz_abs", 32'(lane_out[1:0]), 32'h3);

        // Contention: nmos drives 0, pmos drives 1
        drive(1'b0, 1'b1, 8'b00_00_01_00, 8'b00_00_00_01, 4'b0010);
        chk("cont_net_abs", 32'(net_out), 32'h3);
        chk("cont_flag_abs", 32'(contention), 32'h1);

        // X propagation without contention
        drive(1'b0, 1'b1, 8'b10_10_10_01, 8'b00_00_00_11, 4'b0000);
        chk("xprop_net_abs", 32'(net_out), 32'h3);
        chk("xprop_flag_abs", 32'(contention), 32'h0);

        // Hold for three idle cycles, then reset alongside a valid sample
        drive(1'b0, 1'b1, 8'b01_01_01_01, 8'b01_00_00_00, 4'b0000);
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b0, 8'($urandom), 8'($urandom), 4'($urandom));
        chk("hold_net_abs", 32'(net_out), 32'h1);
        drive(1'b1, 1'b1, 8'b00_00_00_00, 8'b01_01_01_01, 4'b0000);
        chk("midrst_lane_abs", 32'(lane_out), 32'h0000_00AA);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0),
                  8'($urandom), 8'($urandom), 4'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
